// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: per-stage payload layouts, widths, NOP encodings
// and the interstage buffer state encoding.
package pipeline_pkg;

   localparam int unsigned XLEN              = 32;
   localparam int unsigned REG_ADDR_WIDTH    = 5;
   localparam int unsigned ALU_OP_WIDTH      = 4;
   localparam int unsigned STALL_COUNT_WIDTH = 32;
   localparam int unsigned FLUSH_COUNT_WIDTH = 16;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } if_id_t;

   typedef struct packed {
      logic [XLEN-1:0]           pc;
      logic [XLEN-1:0]           rs1_val;
      logic [XLEN-1:0]           rs2_val;
      logic [XLEN-1:0]           imm;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic [ALU_OP_WIDTH-1:0]   alu_op;
      logic                      mem_read;
      logic                      mem_write;
      logic                      reg_write;
   } id_ex_t;

   typedef struct packed {
      logic [XLEN-1:0]           alu_result;
      logic [XLEN-1:0]           store_data;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic                      mem_read;
      logic                      mem_write;
      logic                      reg_write;
   } ex_mem_t;

   typedef struct packed {
      logic [XLEN-1:0]           wb_data;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic                      reg_write;
   } mem_wb_t;

   localparam int unsigned IF_ID_WIDTH  = $bits(if_id_t);
   localparam int unsigned ID_EX_WIDTH  = $bits(id_ex_t);
   localparam int unsigned EX_MEM_WIDTH = $bits(ex_mem_t);
   localparam int unsigned MEM_WB_WIDTH = $bits(mem_wb_t);

   // IF/ID bubble carries "addi x0, x0, 0"; later stages are bubbles when no write/mem op is set.
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam if_id_t  IF_ID_NOP  = '{pc: '0, instr: NOP_INSTR};
   localparam id_ex_t  ID_EX_NOP  = '0;
   localparam ex_mem_t EX_MEM_NOP = '0;
   localparam mem_wb_t MEM_WB_NOP = '0;

   // Encoded as {skid_valid, main_valid}; 2'b10 is unreachable.
   typedef enum logic [1:0] {
      BUF_EMPTY = 2'b00,
      BUF_ONE   = 2'b01,
      BUF_TWO   = 2'b11
   } buf_state_t;

endpackage

// File: rtl/saturating_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module saturating_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/interstage_skid_buffer.sv
// Two-entry skid pipeline register with valid/ready handshake and synchronous flush.
// Define INTERSTAGE_BUFFER_STATS_EN to add stall_count/flush_count outputs.
module interstage_skid_buffer
   import pipeline_pkg::*;
#(
   parameter int unsigned            DATA_WIDTH = 64,
   parameter logic [DATA_WIDTH-1:0]  RESET_DATA = '0
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_WIDTH-1:0]        in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        out_data
`ifdef INTERSTAGE_BUFFER_STATS_EN
   ,
   output logic [STALL_COUNT_WIDTH-1:0] stall_count,
   output logic [FLUSH_COUNT_WIDTH-1:0] flush_count
`endif
);

   buf_state_t            state_q, state_nxt;
   logic [DATA_WIDTH-1:0] main_q, main_nxt;
   logic [DATA_WIDTH-1:0] skid_q, skid_nxt;
   logic                  in_ready_q;
   logic                  in_xfer_c;
   logic                  out_xfer_c;

   assign in_xfer_c  = in_valid && in_ready_q;
   assign out_xfer_c = state_q[0] && out_ready;

   // State and data registers; in_ready is precomputed from the next state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= BUF_EMPTY;
         main_q     <= RESET_DATA;
         skid_q     <= RESET_DATA;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_nxt;
         main_q     <= main_nxt;
         skid_q     <= skid_nxt;
         in_ready_q <= (state_nxt != BUF_TWO);
      end
   end

   // Next-state and data steering; flush wins over any concurrent transfer.
   always_comb begin
      state_nxt = state_q;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      if (flush) begin
         state_nxt = BUF_EMPTY;
         main_nxt  = RESET_DATA;
         skid_nxt  = RESET_DATA;
      end else begin
         case (state_q)
            BUF_EMPTY: begin
               if (in_xfer_c) begin
                  main_nxt  = in_data;
                  state_nxt = BUF_ONE;
               end
            end
            BUF_ONE: begin
               if (in_xfer_c && out_xfer_c) begin
                  main_nxt = in_data;
               end else if (out_xfer_c) begin
                  state_nxt = BUF_EMPTY;
               end else if (in_xfer_c) begin
                  skid_nxt  = in_data;
                  state_nxt = BUF_TWO;
               end
            end
            BUF_TWO: begin
               if (out_xfer_c) begin
                  main_nxt  = skid_q;
                  state_nxt = BUF_ONE;
               end
            end
            default: begin
               state_nxt = BUF_EMPTY;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = state_q[0];
   assign out_data  = main_q;

`ifdef INTERSTAGE_BUFFER_STATS_EN
   logic stall_evt_c;
   logic flush_evt_c;

   assign stall_evt_c = state_q[0] && !out_ready;
   assign flush_evt_c = flush && state_q[0];

   saturating_counter #(
      .WIDTH (STALL_COUNT_WIDTH)
   ) u_stall_count (
      .clock (clock),
      .reset (reset),
      .en    (stall_evt_c),
      .count (stall_count)
   );

   saturating_counter #(
      .WIDTH (FLUSH_COUNT_WIDTH)
   ) u_flush_count (
      .clock (clock),
      .reset (reset),
      .en    (flush_evt_c),
      .count (flush_count)
   );
`endif

endmodule

// File: tb/tb_interstage_skid_buffer.sv
// Directed and scoreboarded bench for interstage_skid_buffer (32-bit payload).
module tb_interstage_skid_buffer;

   localparam int unsigned DW = 32;
   localparam logic [DW-1:0] RST_DATA = 32'hDEAD_BEEF;

   logic          clock = 1'b0;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
`ifdef INTERSTAGE_BUFFER_STATS_EN
   logic [31:0]   stall_count;
   logic [15:0]   flush_count;
`endif
   logic          sat_en;
   logic [2:0]    sat_count;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clock = ~clock;

   interstage_skid_buffer #(
      .DATA_WIDTH (DW),
      .RESET_DATA (RST_DATA)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data)
`ifdef INTERSTAGE_BUFFER_STATS_EN
      ,
      .stall_count (stall_count),
      .flush_count (flush_count)
`endif
   );

   saturating_counter #(
      .WIDTH (3)
   ) u_sat (
      .clock (clock),
      .reset (reset),
      .en    (sat_en),
      .count (sat_count)
   );

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      cycle();
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sat_en = 1'b0;
      cycle();
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
      total_cnt++;
      if (out_data !== RST_DATA) $display("FAIL reset_out_data got %h want %h", out_data, RST_DATA); else pass_cnt++;
      reset = 1'b0;
      cycle();
   endtask

   task automatic test_streaming();
      logic [DW-1:0] vals [3];
      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = vals[i];
         cycle();
         total_cnt++;
         if (out_valid !== 1'b1 || out_data !== vals[i])
            $display("FAIL stream_data[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, vals[i]);
         else pass_cnt++;
         total_cnt++;
         if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); else pass_cnt++;
      end
      in_valid = 1'b0;
      cycle();
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL stream_drain got %b want 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hA;
      cycle();
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL bp_first_in_ready got %b want 1", in_ready); else pass_cnt++;
      in_data = 32'hB;
      cycle();
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL bp_full_in_ready got %b want 0", in_ready); else pass_cnt++;
      total_cnt++;
      if (out_data !== 32'hA) $display("FAIL bp_hold_data got %h want 0000000a", out_data); else pass_cnt++;
      in_valid = 1'b0;
      cycle();
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== 32'hA)
         $display("FAIL bp_stable got v=%b d=%h want v=1 d=0000000a", out_valid, out_data);
      else pass_cnt++;
      out_ready = 1'b1;
      cycle();
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== 32'hB)
         $display("FAIL bp_second got v=%b d=%h want v=1 d=0000000b", out_valid, out_data);
      else pass_cnt++;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL bp_ready_back got %b want 1", in_ready); else pass_cnt++;
      cycle();
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", out_valid); else pass_cnt++;
   endtask

   task automatic fill_two(input logic [DW-1:0] a, input logic [DW-1:0] b);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = a;
      cycle();
      in_data   = b;
      cycle();
      in_valid  = 1'b0;
   endtask

   task automatic test_flush_collision();
      fill_two(32'h1, 32'h2);
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL flush_pre_full got %b want 0", in_ready); else pass_cnt++;
      flush = 1'b1; in_valid = 1'b1; in_data = 32'hC; out_ready = 1'b1;
      cycle();
      flush = 1'b0; in_valid = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL flush_state got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
      else pass_cnt++;
      total_cnt++;
      if (out_data !== RST_DATA) $display("FAIL flush_data got %h want %h", out_data, RST_DATA); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         cycle();
         total_cnt++;
         if (out_valid !== 1'b0 || out_data === 32'hC)
            $display("FAIL flush_ghost[%0d] got v=%b d=%h want v=0", i, out_valid, out_data);
         else pass_cnt++;
      end
   endtask

   task automatic test_async_reset();
      fill_two(32'h5, 32'h6);
      #2;
      reset = 1'b1;
      #1;
      total_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL areset_state got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
      else pass_cnt++;
      total_cnt++;
      if (out_data !== RST_DATA) $display("FAIL areset_data got %h want %h", out_data, RST_DATA); else pass_cnt++;
      cycle();
      reset = 1'b0;
      out_ready = 1'b1;
      cycle();
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL areset_no_survivor got %b want 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_random();
      logic [DW-1:0] q[$];
      logic          in_x, out_x, stalled;
      logic [DW-1:0] prev_data, exp;
      int            errs;
      errs = 0;
      stalled = 1'b0;
      prev_data = '0;
      in_valid = 1'b0;
      for (int c = 0; c < 10004; c++) begin
         if (c >= 10000) begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end else begin
            if (!in_valid) begin
               in_valid = ($urandom_range(0, 3) != 0);
               in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 2) != 0);
         end
         if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
            errs++;
            if (errs < 5)
               $display("FAIL rand_flags cyc %0d got ov=%b ir=%b want occupancy %0d", c, out_valid, in_ready, q.size());
         end
         if (stalled && out_data !== prev_data) begin
            errs++;
            if (errs < 5) $display("FAIL rand_stable cyc %0d got %h want %h", c, out_data, prev_data);
         end
         in_x  = in_valid && in_ready;
         out_x = out_valid && out_ready;
         if (out_x) begin
            exp = (q.size() > 0) ? q.pop_front() : 'x;
            if (out_data !== exp) begin
               errs++;
               if (errs < 5) $display("FAIL rand_order cyc %0d got %h want %h", c, out_data, exp);
            end
         end
         if (in_x) q.push_back(in_data);
         stalled   = out_valid && !out_ready;
         prev_data = out_data;
         cycle();
         if (in_x) in_valid = 1'b0;
      end
      total_cnt++;
      if (errs != 0) $display("FAIL rand_scoreboard got %0d errors want 0", errs); else pass_cnt++;
      total_cnt++;
      if (q.size() != 0 || out_valid !== 1'b0)
         $display("FAIL rand_drain got left=%0d ov=%b want left=0 ov=0", q.size(), out_valid);
      else pass_cnt++;
   endtask

   task automatic test_saturation();
      sat_en = 1'b1;
      for (int i = 0; i < 5; i++) cycle();
      total_cnt++;
      if (sat_count !== 3'd5) $display("FAIL sat_count_5 got %0d want 5", sat_count); else pass_cnt++;
      for (int i = 0; i < 4; i++) cycle();
      total_cnt++;
      if (sat_count !== 3'd7) $display("FAIL sat_count_max got %0d want 7", sat_count); else pass_cnt++;
      sat_en = 1'b0;
      cycle();
      total_cnt++;
      if (sat_count !== 3'd7) $display("FAIL sat_count_hold got %0d want 7", sat_count); else pass_cnt++;
   endtask

`ifdef INTERSTAGE_BUFFER_STATS_EN
   task automatic test_stats();
      do_reset();
      total_cnt++;
      if (stall_count !== 32'd0 || flush_count !== 16'd0)
         $display("FAIL stats_reset got s=%0d f=%0d want 0 0", stall_count, flush_count);
      else pass_cnt++;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h77;
      cycle();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      total_cnt++;
      if (stall_count !== 32'd5) $display("FAIL stats_stall got %0d want 5", stall_count); else pass_cnt++;
      flush = 1'b1; out_ready = 1'b1;
      cycle();
      flush = 1'b0;
      total_cnt++;
      if (flush_count !== 16'd1 || stall_count !== 32'd5)
         $display("FAIL stats_flush got s=%0d f=%0d want 5 1", stall_count, flush_count);
      else pass_cnt++;
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      total_cnt++;
      if (flush_count !== 16'd1) $display("FAIL stats_flush_empty got %0d want 1", flush_count); else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush_collision();
      test_async_reset();
      test_random();
      do_reset();
      test_saturation();
`ifdef INTERSTAGE_BUFFER_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
